flight_loop_sched: RTL and testbench

Fixed-rate control-loop scheduler for the flight controller. It brings up the MPU, then on every loop tick runs one sequence: request a 12-byte MPU burst, pack it into six signed 16-bit sensor words, start the PID, and hand the result to the PWM stage. It sits between the MPU, PID and PWM blocks and replaces ad-hoc top-level sequencing. It also reports timeouts, retries and loop overruns.

---
 rtl/flight_pkg.sv | 26 ++
 rtl/flight_loop_sched_packer.sv | 55 +++++
 rtl/flight_loop_sched.sv | 155 +++++++++++++++
 tb/tb_flight_loop_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flight_pkg.sv
// Shared types and constants for the flight-controller loop scheduler.
// Sensor words are big-endian, signed, in ax..gz order.
package flight_pkg;

  typedef enum logic [2:0] {
    RESET_INIT = 3'd0,
    WAIT_INIT  = 3'd1,
    WAIT_TICK  = 3'd2,
    CAPTURE    = 3'd3,
    CALC       = 3'd4,
    PWM_WAIT   = 3'd5,
    FAULT      = 3'd6
  } sched_state_t;

  localparam int MPU_BURST_BYTES = 12;

  typedef struct packed {
    logic signed [15:0] ax;
    logic signed [15:0] ay;
    logic signed [15:0] az;
    logic signed [15:0] gx;
    logic signed [15:0] gy;
    logic signed [15:0] gz;
  } imu_sample_t;

endpackage

// File: rtl/flight_loop_sched_packer.sv
// Collects one MPU burst and assembles it into six big-endian words.
// The sample register only changes when the final byte arrives.
module mpu_byte_packer
  import flight_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic        data_oe,
  input  logic [7:0]  data,
  output logic        last,
  output imu_sample_t sample,
  output logic        sample_valid
);

  localparam logic [3:0] LAST_IDX = 4'(MPU_BURST_BYTES - 1);
  localparam logic [3:0] FULL_CNT = 4'(MPU_BURST_BYTES);

  logic [3:0] byte_cnt;
  logic [7:0] held [MPU_BURST_BYTES-1];
  logic       take;

  assign take = accept && data_oe && (byte_cnt < FULL_CNT);
  assign last = take && (byte_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      for (int i = 0; i < MPU_BURST_BYTES - 1; i++)
        held[i] <= '0;
    end else begin
      sample_valid <= last;
      if (clear) begin
        byte_cnt <= '0;
      end else if (take) begin
        byte_cnt <= byte_cnt + 1'b1;
        if (!last)
          held[byte_cnt] <= data;
      end
      // final byte goes straight into gz, bypassing the hold buffer
      if (last) begin
        sample.ax <= {held[0], held[1]};
        sample.ay <= {held[2], held[3]};
        sample.az <= {held[4], held[5]};
        sample.gx <= {held[6], held[7]};
        sample.gy <= {held[8], held[9]};
        sample.gz <= {held[10], data};
      end
    end
  end

endmodule

// File: rtl/flight_loop_sched.sv
// Fixed-rate loop scheduler: MPU init, burst capture, PID start, PWM load.
// Tracks wait-state timeouts, capture retries and missed loop ticks.
module flight_loop_sched
  import flight_pkg::*;
#(
  parameter int CLK_MAIN    = 50000000,
  parameter int LOOP_HZ     = 500,
  parameter int TIMEOUT_CYC = 20000,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        mpu_init,
  input  logic        mpu_init_done,
  output logic        mpu_transfer,
  input  logic        mpu_data_oe,
  input  logic [7:0]  mpu_data,
  input  logic        mpu_busy,
  output logic        calc_pid_oe,
  input  logic        pid_done,
  output logic        pwm_update,
  input  logic        pwm_busy,
  output imu_sample_t sensor,
  output logic        sample_valid,
  output logic        fault,
  output logic [7:0]  overrun_cnt
);

  localparam int LOOP_CYC = CLK_MAIN / LOOP_HZ;
  localparam int TCW      = $clog2(LOOP_CYC + 1);
  localparam int OCW      = $clog2(TIMEOUT_CYC + 1);

  localparam logic [TCW-1:0] TICK_LAST = TCW'(LOOP_CYC - 1);
  localparam logic [OCW-1:0] TO_LAST   = OCW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]     RETRY_MAX = 8'(MAX_RETRY - 1);

  sched_state_t state, state_n;

  logic [TCW-1:0] tick_cnt;
  logic [OCW-1:0] wait_cnt;
  logic [7:0]     retry;

  logic tick, waiting, timeout, busy_tick;
  logic go_init, go_xfer, go_pid, go_pwm;
  logic retry_inc, burst_last;
  logic pk_clear, pk_accept;

  assign tick      = (tick_cnt == TICK_LAST);
  assign waiting   = state inside {WAIT_INIT, CAPTURE, CALC, PWM_WAIT};
  assign timeout   = waiting && (wait_cnt == TO_LAST);
  assign busy_tick = tick && !(state inside {WAIT_TICK, FAULT});

  // a capture timeout drops any byte arriving in the same cycle
  assign pk_accept = (state == CAPTURE) && !timeout;
  assign pk_clear  = !pk_accept;

  always_comb begin
    state_n   = state;
    go_init   = 1'b0;
    go_xfer   = 1'b0;
    go_pid    = 1'b0;
    go_pwm    = 1'b0;
    retry_inc = 1'b0;
    unique case (state)
      RESET_INIT: begin
        go_init = 1'b1;
        state_n = WAIT_INIT;
      end
      WAIT_INIT: begin
        if (mpu_init_done)
          state_n = WAIT_TICK;
        else if (timeout)
          state_n = FAULT;
      end
      WAIT_TICK: begin
        if (tick && enable && !mpu_busy) begin
          go_xfer = 1'b1;
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        if (timeout) begin
          retry_inc = 1'b1;
          state_n   = (retry >= RETRY_MAX) ? FAULT : WAIT_TICK;
        end else if (burst_last) begin
          go_pid  = 1'b1;
          state_n = CALC;
        end
      end
      CALC: begin
        if (pid_done)
          state_n = PWM_WAIT;
        else if (timeout)
          state_n = FAULT;
      end
      PWM_WAIT: begin
        if (!pwm_busy) begin
          go_pwm  = 1'b1;
          state_n = WAIT_TICK;
        end else if (timeout) begin
          state_n = FAULT;
        end
      end
      FAULT: state_n = FAULT;
      default: state_n = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RESET_INIT;
      tick_cnt     <= '0;
      wait_cnt     <= '0;
      retry        <= '0;
      mpu_init     <= 1'b0;
      mpu_transfer <= 1'b0;
      calc_pid_oe  <= 1'b0;
      pwm_update   <= 1'b0;
      fault        <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      state        <= state_n;
      tick_cnt     <= tick ? '0 : tick_cnt + 1'b1;
      mpu_init     <= go_init;
      mpu_transfer <= go_xfer;
      calc_pid_oe  <= go_pid;
      pwm_update   <= go_pwm;
      fault        <= (state_n == FAULT);
      if (state_n != state)
        wait_cnt <= '0;
      else if (wait_cnt != TO_LAST)
        wait_cnt <= wait_cnt + 1'b1;
      if (retry_inc)
        retry <= retry + 1'b1;
      else if (go_pid)
        retry <= '0;
      if (busy_tick && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 1'b1;
    end
  end

  mpu_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (pk_clear),
    .accept       (pk_accept),
    .data_oe      (mpu_data_oe),
    .data         (mpu_data),
    .last         (burst_last),
    .sample       (sensor),
    .sample_valid (sample_valid)
  );

endmodule

// File: tb/tb_flight_loop_sched.sv
// Directed bench for flight_loop_sched: burst vector table plus
// hand-written sequences for pwm backpressure, overrun, reset and fault.
`timescale 1ns/1ps
module tb_flight_loop_sched;
  import flight_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        mpu_init;
  logic        mpu_init_done;
  logic        mpu_transfer;
  logic        mpu_data_oe;
  logic [7:0]  mpu_data;
  logic        mpu_busy;
  logic        calc_pid_oe;
  logic        pid_done;
  logic        pwm_update;
  logic        pwm_busy;
  imu_sample_t sensor;
  logic        sample_valid;
  logic        fault;
  logic [7:0]  overrun_cnt;

  // LOOP_CYC = 100, TIMEOUT_CYC above two loop periods
  flight_loop_sched #(
    .CLK_MAIN    (1000),
    .LOOP_HZ     (10),
    .TIMEOUT_CYC (250),
    .MAX_RETRY   (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .mpu_init      (mpu_init),
    .mpu_init_done (mpu_init_done),
    .mpu_transfer  (mpu_transfer),
    .mpu_data_oe   (mpu_data_oe),
    .mpu_data      (mpu_data),
    .mpu_busy      (mpu_busy),
    .calc_pid_oe   (calc_pid_oe),
    .pid_done      (pid_done),
    .pwm_update    (pwm_update),
    .pwm_busy      (pwm_busy),
    .sensor        (sensor),
    .sample_valid  (sample_valid),
    .fault         (fault),
    .overrun_cnt   (overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [95:0]        bytes;
    logic signed [15:0] ax;
    logic signed [15:0] ay;
    logic signed [15:0] az;
    logic signed [15:0] gx;
    logic signed [15:0] gy;
    logic signed [15:0] gz;
    logic [7:0]         busy;
  } vec_t;

  vec_t vecs [4];
  int   tests = 0;
  int   fails = 0;
  int   n_init = 0, n_xfer = 0, n_sv = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_sensor(input string tag, input vec_t v);
    chk({tag, "_ax"}, sensor.ax, v.ax);
    chk({tag, "_ay"}, sensor.ay, v.ay);
    chk({tag, "_az"}, sensor.az, v.az);
    chk({tag, "_gx"}, sensor.gx, v.gx);
    chk({tag, "_gy"}, sensor.gy, v.gy);
    chk({tag, "_gz"}, sensor.gz, v.gz);
  endtask

  task automatic wait_xfer(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      cyc(1);
      if (mpu_transfer) ok = 1'b1;
    end
  endtask

  task automatic send(input vec_t v, input int n);
    for (int i = 0; i < n; i++) begin
      mpu_data_oe = 1'b1;
      mpu_data    = v.bytes[95-8*i -: 8];
      cyc(1);
    end
    mpu_data_oe = 1'b0;
  endtask

  // one complete loop: tick, burst (+1 stray byte), PID, PWM
  task automatic run_loop(input vec_t v, input int pid_hold);
    bit ok;
    int sv0, hits;
    wait_xfer(400, ok);
    chk("xfer_start", 32'(ok), 1);
    if (!ok) return;
    sv0 = n_sv;
    send(v, 12);
    chk("sv_latency", 32'(sample_valid), 1);
    chk("pid_latency", 32'(calc_pid_oe), 1);
    mpu_data_oe = 1'b1;
    mpu_data    = 8'h55;
    cyc(1);
    mpu_data_oe = 1'b0;
    chk("sv_width", 32'(sample_valid), 0);
    chk("sv_count", 32'(n_sv - sv0), 1);
    chk_sensor("burst", v);
    cyc(pid_hold);
    pwm_busy = (v.busy != 0);
    pid_done = 1'b1;
    cyc(1);
    pid_done = 1'b0;
    hits = 0;
    for (int j = 0; j < int'(v.busy); j++) begin
      cyc(1);
      hits += int'(pwm_update);
    end
    chk("pwm_held", 32'(hits), 0);
    pwm_busy = 1'b0;
    cyc(1);
    chk("pwm_first", 32'(pwm_update), 1);
    cyc(1);
    chk("pwm_width", 32'(pwm_update), 0);
  endtask

  always @(negedge clk) begin
    logic [3:0] strobes;
    strobes = {mpu_init, mpu_transfer, calc_pid_oe, pwm_update};
    if (mpu_init)     n_init++;
    if (mpu_transfer) n_xfer++;
    if (sample_valid) n_sv++;
    if (|strobes)
      chk("strobe_overlap", 32'($countones(strobes)), 1);
    if (sample_valid || calc_pid_oe)
      chk("sv_pid_pair", 32'(sample_valid), 32'(calc_pid_oe));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    bit ok;
    int sv0, x0, i0;

    vecs[0] = '{bytes: 96'h1234FFFE4000001080007FFF,
                ax: 16'sh1234, ay: -16'sd2, az: 16'sh4000,
                gx: 16'sd16, gy: 16'sh8000, gz: 16'sd32767,
                busy: 8'd0};
    vecs[1] = '{bytes: 96'h0102030405060708090A0B0C,
                ax: 16'sh0102, ay: 16'sh0304, az: 16'sh0506,
                gx: 16'sh0708, gy: 16'sh090A, gz: 16'sh0B0C,
                busy: 8'd30};
    vecs[2] = '{bytes: 96'h0,
                ax: 16'sd0, ay: 16'sd0, az: 16'sd0,
                gx: 16'sd0, gy: 16'sd0, gz: 16'sd0,
                busy: 8'd0};
    vecs[3] = '{bytes: 96'hA55AFFFF0001C33C7F000080,
                ax: 16'shA55A, ay: -16'sd1, az: 16'sd1,
                gx: 16'shC33C, gy: 16'sh7F00, gz: 16'sh0080,
                busy: 8'd0};

    rst_n = 1'b0; enable = 1'b0; mpu_init_done = 1'b0;
    mpu_data_oe = 1'b0; mpu_data = 8'h00; mpu_busy = 1'b0;
    pid_done = 1'b0; pwm_busy = 1'b0;
    cyc(3);
    chk("rst_strobes", 32'({mpu_init, mpu_transfer, calc_pid_oe,
                            pwm_update, sample_valid, fault}), 0);
    chk("rst_sensor", 32'(sensor == '0), 1);
    chk("rst_overrun", 32'(overrun_cnt), 0);
    chk("rst_state", 32'(dut.state), 32'(RESET_INIT));

    // bring-up
    rst_n  = 1'b1;
    enable = 1'b1;
    cyc(1);
    chk("init_pulse", 32'(mpu_init), 1);
    cyc(49);
    mpu_init_done = 1'b1;
    cyc(1);
    chk("init_state", 32'(dut.state), 32'(WAIT_TICK));
    chk("init_count", 32'(n_init), 1);
    chk("init_fault", 32'(fault), 0);
    chk("init_overrun", 32'(overrun_cnt), 0);

    // burst table; vecs[1] carries 30 cycles of pwm backpressure
    for (int i = 0; i < 4; i++)
      run_loop(vecs[i], 0);
    chk("table_overrun", 32'(overrun_cnt), 0);
    chk("table_fault", 32'(fault), 0);

    // PID held across two loop ticks
    run_loop(vecs[3], 205);
    chk("ovr_count", 32'(overrun_cnt), 2);
    run_loop(vecs[0], 0);
    chk("ovr_resume_fault", 32'(fault), 0);
    chk("ovr_resume_cnt", 32'(overrun_cnt), 2);

    // reset after byte 5 of a burst
    wait_xfer(400, ok);
    chk("mid_xfer", 32'(ok), 1);
    send(vecs[0], 5);
    rst_n = 1'b0;
    mpu_init_done = 1'b0;
    cyc(1);
    chk("mid_strobes", 32'({mpu_init, mpu_transfer, calc_pid_oe,
                            pwm_update, sample_valid, fault}), 0);
    chk("mid_sensor", 32'(sensor == '0), 1);
    chk("mid_overrun", 32'(overrun_cnt), 0);
    i0 = n_init;
    rst_n = 1'b1;
    cyc(1);
    chk("reinit_pulse", 32'(mpu_init), 1);
    cyc(9);
    mpu_init_done = 1'b1;
    cyc(1);
    chk("reinit_count", 32'(n_init - i0), 1);
    chk("reinit_state", 32'(dut.state), 32'(WAIT_TICK));
    run_loop(vecs[1], 0);

    // three short bursts in a row
    sv0 = n_sv;
    for (int r = 0; r < 3; r++) begin
      wait_xfer(400, ok);
      chk("short_xfer", 32'(ok), 1);
      chk("short_nofault", 32'(fault), 0);
      send(vecs[3], 7);
    end
    for (int i = 0; i < 300 && !fault; i++)
      cyc(1);
    chk("short_fault", 32'(fault), 1);
    chk("short_sv", 32'(n_sv - sv0), 0);
    chk_sensor("short_keep", vecs[1]);
    x0 = n_xfer;
    cyc(250);
    chk("fault_quiet", 32'(n_xfer - x0), 0);
    chk("fault_sticky", 32'(fault), 1);

    rst_n = 1'b0;
    cyc(1);
    chk("fault_clear", 32'(fault), 0);
    rst_n = 1'b1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
